// File: rtl/ex_iter_divider.sv
// rtl/ex_iter_divider.sv - iterative restoring radix-2 divider, UNROLL quotient bits per cycle
module ex_iter_divider #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz,
    output logic             busy
);
    localparam int N     = WIDTH / UNROLL;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [TAG_W-1:0]   r_tag;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dbz;

    logic               w_accept;
    logic               w_dvs_zero;
    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_abs;
    logic [WIDTH-1:0]   w_dvs_abs;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;

    assign in_ready   = ~flush & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
    assign w_accept   = in_valid & in_ready;
    assign w_dvs_zero = (in_divisor == '0);
    assign w_dvd_neg  = in_signed & in_dividend[WIDTH-1];
    assign w_dvs_neg  = in_signed & in_divisor[WIDTH-1];
    // Negating MIN yields MIN again, which read unsigned is exactly 2^(WIDTH-1).
    assign w_dvd_abs  = w_dvd_neg ? -in_dividend : in_dividend;
    assign w_dvs_abs  = w_dvs_neg ? -in_divisor  : in_divisor;

    always_comb begin
        logic [WIDTH:0] v_sh;
        w_rem_nx = r_rem;
        w_quo_nx = r_quo;
        v_sh     = '0;
        for (int k = 0; k < UNROLL; k++) begin
            v_sh = {w_rem_nx, w_quo_nx[WIDTH-1]};
            if (v_sh >= {1'b0, r_dvs}) begin
                v_sh     = v_sh - {1'b0, r_dvs};
                w_quo_nx = {w_quo_nx[WIDTH-2:0], 1'b1};
            end else begin
                w_quo_nx = {w_quo_nx[WIDTH-2:0], 1'b0};
            end
            w_rem_nx = v_sh[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_tag    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (flush) begin
            r_state <= S_IDLE;
        end else if (w_accept) begin
            r_tag <= in_tag;
            r_cnt <= CNT_W'(N);
            r_dvs <= w_dvs_abs;
            if (w_dvs_zero) begin
                r_state  <= S_DONE;
                r_dbz    <= 1'b1;
                r_quo    <= '1;
                r_rem    <= in_dividend;
                r_sign_q <= 1'b0;
                r_sign_r <= 1'b0;
            end else begin
                r_state  <= S_ITER;
                r_dbz    <= 1'b0;
                r_quo    <= w_dvd_abs;
                r_rem    <= '0;
                r_sign_q <= w_dvd_neg ^ w_dvs_neg;
                r_sign_r <= w_dvd_neg;
            end
        end else begin
            case (r_state)
                S_ITER: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) r_state <= S_DONE;
                end
                S_DONE: if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out_quot  = r_sign_q ? -r_quo : r_quo;
    assign out_rem   = r_sign_r ? -r_rem : r_rem;
    assign out_tag   = r_tag;
    assign out_dbz   = r_dbz;
endmodule

// File: tb/tb_ex_iter_divider.sv
// tb/tb_ex_iter_divider.sv - directed and random checks of ex_iter_divider at UNROLL 1, 2 and 4
module tb_ex_iter_divider;
    logic        clk;
    logic        resetn;
    logic        flush_a     [3];
    logic        in_valid_a  [3];
    logic        in_ready_a  [3];
    logic        in_signed_a [3];
    logic [31:0] dvd_a       [3];
    logic [31:0] dvs_a       [3];
    logic [4:0]  in_tag_a    [3];
    logic        out_valid_a [3];
    logic        out_ready_a [3];
    logic [31:0] quot_a      [3];
    logic [31:0] rem_a       [3];
    logic [4:0]  out_tag_a   [3];
    logic        dbz_a       [3];
    logic        busy_a      [3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ex_iter_divider #(.WIDTH(32), .UNROLL(1 << g), .TAG_W(5)) u_dut (
            .clk        (clk),
            .resetn     (resetn),
            .flush      (flush_a[g]),
            .in_valid   (in_valid_a[g]),
            .in_ready   (in_ready_a[g]),
            .in_signed  (in_signed_a[g]),
            .in_dividend(dvd_a[g]),
            .in_divisor (dvs_a[g]),
            .in_tag     (in_tag_a[g]),
            .out_valid  (out_valid_a[g]),
            .out_ready  (out_ready_a[g]),
            .out_quot   (quot_a[g]),
            .out_rem    (rem_a[g]),
            .out_tag    (out_tag_a[g]),
            .out_dbz    (dbz_a[g]),
            .busy       (busy_a[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, done in 64 bits.
    function automatic void model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dbz);
        longint sa, sb, q64, r64;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; dbz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q64 = sa / sb;
            r64 = sa % sb;
            q = q64[31:0]; r = r64[31:0]; dbz = 1'b0;
        end else begin
            q = a / b; r = a % b; dbz = 1'b0;
        end
    endfunction

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic issue(input int g, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        in_valid_a[g] = 1'b1; in_signed_a[g] = sgn; dvd_a[g] = a; dvs_a[g] = b; in_tag_a[g] = tag;
        #1;
        chk($sformatf("in_ready%0d", g), {31'b0, in_ready_a[g]}, 32'd1);
        @(posedge clk); #1;
        in_valid_a[g] = 1'b0; out_ready_a[g] = 1'b0;
        dvd_a[g] = $urandom; dvs_a[g] = $urandom; in_signed_a[g] = ~sgn; in_tag_a[g] = ~tag;
    endtask

    task automatic collect(input int g, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input bit release_it);
        logic [31:0] eq, er;
        logic        ed;
        int          cyc;
        model(sgn, a, b, eq, er, ed);
        cyc = 0;
        while (!out_valid_a[g] && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        chk($sformatf("lat%0d %h/%h", g, a, b), cyc, (b == 0) ? 32'd0 : (32'd32 >> g));
        chk($sformatf("quot%0d %0d %h/%h", g, sgn, a, b), quot_a[g], eq);
        chk($sformatf("rem%0d %0d %h/%h", g, sgn, a, b), rem_a[g], er);
        chk($sformatf("tag%0d", g), {27'b0, out_tag_a[g]}, {27'b0, tag});
        chk($sformatf("dbz%0d", g), {31'b0, dbz_a[g]}, {31'b0, ed});
        if (release_it) begin
            out_ready_a[g] = 1'b1;
            @(posedge clk); #1;
            out_ready_a[g] = 1'b0;
            chk($sformatf("drop%0d", g), {31'b0, out_valid_a[g]}, 32'd0);
        end
    endtask

    task automatic run_op(input int g, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag);
        issue(g, sgn, a, b, tag);
        collect(g, sgn, a, b, tag, 1'b1);
    endtask

    initial begin
        int seen;
        logic [31:0] eq, er, a, b;
        logic        ed;
        for (int g = 0; g < 3; g++) begin
            flush_a[g] = 0; in_valid_a[g] = 0; in_signed_a[g] = 0; dvd_a[g] = 0;
            dvs_a[g] = 0; in_tag_a[g] = 0; out_ready_a[g] = 0;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, out_valid_a[0]}, 32'd0);
        chk("rst_busy", {31'b0, busy_a[0]}, 32'd0);
        chk("rst_ready", {31'b0, in_ready_a[0]}, 32'd1);
        chk("rst_quot", quot_a[0], 32'd0);
        chk("rst_rem", rem_a[0], 32'd0);
        chk("rst_tag", {27'b0, out_tag_a[0]}, 32'd0);
        chk("rst_dbz", {31'b0, dbz_a[0]}, 32'd0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        run_op(0, 1'b0, 32'd100, 32'd7, 5'd3);
        run_op(0, 1'b1, -32'sd7, 32'd2, 5'd4);
        run_op(0, 1'b1, 32'd7, -32'sd2, 5'd5);
        run_op(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
        run_op(0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        run_op(0, 1'b1, 32'h0000_1234, 32'd0, 5'd8);

        // Flush mid-iteration with a competing request in the same cycle.
        issue(0, 1'b0, 32'd100, 32'd7, 5'd9);
        repeat (9) begin @(posedge clk); #1; end
        flush_a[0] = 1'b1; in_valid_a[0] = 1'b1; dvd_a[0] = 32'd50; dvs_a[0] = 32'd5;
        #1;
        chk("flush_ready", {31'b0, in_ready_a[0]}, 32'd0);
        @(posedge clk); #1;
        flush_a[0] = 1'b0; in_valid_a[0] = 1'b0;
        chk("flush_busy", {31'b0, busy_a[0]}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid_a[0]) seen++;
        end
        chk("flush_no_valid", seen, 32'd0);
        run_op(0, 1'b0, 32'd9, 32'd3, 5'd10);

        // Async reset mid-iteration.
        issue(0, 1'b1, -32'sd1000, 32'd3, 5'd11);
        repeat (5) begin @(posedge clk); #1; end
        resetn = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy_a[0]}, 32'd0);
        chk("midrst_valid", {31'b0, out_valid_a[0]}, 32'd0);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // Back-pressure hold, then zero-bubble handoff, on each unroll factor.
        for (int g = 0; g < 3; g++) begin
            issue(g, 1'b1, -32'sd12345, 32'd77, 5'd12);
            collect(g, 1'b1, -32'sd12345, 32'd77, 5'd12, 1'b0);
            model(1'b1, -32'sd12345, 32'd77, eq, er, ed);
            repeat (5) begin
                @(posedge clk); #1;
                chk($sformatf("hold_valid%0d", g), {31'b0, out_valid_a[g]}, 32'd1);
                chk($sformatf("hold_quot%0d", g), quot_a[g], eq);
                chk($sformatf("hold_rem%0d", g), rem_a[g], er);
            end
            out_ready_a[g] = 1'b1;
            issue(g, 1'b0, 32'd1000, 32'd9, 5'd13);
            chk($sformatf("b2b_valid%0d", g), {31'b0, out_valid_a[g]}, 32'd0);
            collect(g, 1'b0, 32'd1000, 32'd9, 5'd13, 1'b1);
        end

        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 16; i++) begin
                a = $urandom;
                case ($urandom_range(0, 7))
                    0: b = 32'd0;
                    1: b = 32'hFFFF_FFFF;
                    2: b = $urandom_range(1, 15);
                    3: b = 32'h8000_0000;
                    default: b = $urandom;
                endcase
                if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
                run_op(g, 1'($urandom_range(0, 1)), a, b, 5'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
